// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Conditional-branch direction predictor for the fetch stage. A table of
//   2**INDEX_BITS saturating counters is indexed by the PC index bits XOR'd
//   with a speculative global history register (GHR). The GHR shifts in each
//   prediction at predict time and is repaired from the carried snapshot
//   when EX reports a mispredict. After reset a sweep FSM writes every
//   counter to weakly-not-taken before the predictor goes live.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   pred_valid      fetch requests a prediction this cycle
//   pred_pc_idx     PC index bits of the fetched branch
//   pred_taken      predicted direction (combinational, 0 while not ready)
//   pred_index      hashed table index, carried down the pipe for update
//   pred_ghr        GHR snapshot before this prediction's shift
//   upd_valid       resolved conditional branch from EX
//   upd_index       pred_index carried with that branch
//   upd_taken       actual direction
//   upd_mispredict  direction was mispredicted; repair the GHR
//   upd_ghr         pred_ghr carried with that branch
//   ready           table initialised; prediction/update active
module gshare_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid,
  input  logic [INDEX_BITS-1:0] pred_pc_idx,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  output logic [HIST_BITS-1:0]  pred_ghr,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic [HIST_BITS-1:0]  upd_ghr,
  output logic                  ready
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0]   WEAK_NT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
  localparam logic [INDEX_BITS-1:0] LAST_PTR = INDEX_BITS'(ENTRIES - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                state, state_next;
  logic [INDEX_BITS-1:0] ptr, ptr_next;
  logic [HIST_BITS-1:0]  ghr, ghr_next;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] hash_idx;

  logic [CTR_BITS-1:0]   ctr_table [ENTRIES];
  logic                  tbl_we;
  logic [INDEX_BITS-1:0] tbl_idx;
  logic [CTR_BITS-1:0]   tbl_wdata;

  // Saturating counter step: never wraps in either direction.
  function automatic logic [CTR_BITS-1:0] sat_update(
    input logic [CTR_BITS-1:0] ctr,
    input logic                taken
  );
    logic [CTR_BITS-1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) res = ctr + 1'b1;
    end else begin
      if (ctr != '0) res = ctr - 1'b1;
    end
    return res;
  endfunction

  // Shift one outcome into a history value. Built by truncating {h, b} so
  // that the single-bit history case needs no special slice.
  function automatic logic [HIST_BITS-1:0] ghr_shift(
    input logic [HIST_BITS-1:0] h,
    input logic                 b
  );
    logic [HIST_BITS:0] t;
    t = {h, b};
    return t[HIST_BITS-1:0];
  endfunction

  // History is zero-extended up to the index width before hashing.
  always_comb begin
    ghr_ext                 = '0;
    ghr_ext[HIST_BITS-1:0]  = ghr;
    hash_idx                = pred_pc_idx ^ ghr_ext;
  end

  assign pred_index = hash_idx;
  assign pred_ghr   = ghr;
  assign ready      = (state == S_READY);
  // No bypass: a same-cycle update to this entry is seen only next cycle.
  assign pred_taken = ready & ctr_table[hash_idx][CTR_BITS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      ptr   <= '0;
      ghr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      ghr   <= ghr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    ghr_next   = ghr;
    tbl_we     = 1'b0;
    tbl_idx    = ptr;
    tbl_wdata  = WEAK_NT;
    case (state)
      S_INIT: begin
        // Sweep owns the table; predict/update requests are ignored.
        tbl_we   = 1'b1;
        ptr_next = ptr + 1'b1;
        ghr_next = '0;
        if (ptr == LAST_PTR) state_next = S_READY;
      end
      S_READY: begin
        if (upd_valid) begin
          tbl_we    = 1'b1;
          tbl_idx   = upd_index;
          tbl_wdata = sat_update(ctr_table[upd_index], upd_taken);
        end
        // Mispredict repair wins over the speculative shift of this cycle.
        if (upd_valid && upd_mispredict) begin
          ghr_next = ghr_shift(upd_ghr, upd_taken);
        end else if (pred_valid) begin
          ghr_next = ghr_shift(ghr, pred_taken);
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  // Counter storage carries no reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (tbl_we) ctr_table[tbl_idx] <= tbl_wdata;
  end

endmodule
